// File: rtl/crg_cfg_sequencer.sv
// Clock-reconfiguration sequencer: gates an output, switches its source, optionally pulses its reset, then ungates.
// Optional macro CRG_SEQ_ABORT_EN adds abort_i, which cancels a request in GATE or RESET.
module crg_cfg_sequencer #(
  parameter int M           = 4,
  parameter int N           = 8,
  parameter int GATE_WAIT   = 8,
  parameter int SWITCH_WAIT = 32,
  parameter int RST_CYCLES  = 16
) (
  input  logic                           ref_clk_i,
  input  logic                           arst_ni,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [$clog2(N)-1:0]           req_idx_i,
  input  logic [$clog2(M)-1:0]           req_sel_i,
  input  logic                           req_en_i,
  input  logic                           req_rst_i,
`ifdef CRG_SEQ_ABORT_EN
  input  logic                           abort_i,
`endif
  output logic [N-1:0][$clog2(M)-1:0]    sel_o,
  output logic [N-1:0]                   en_o,
  output logic [N-1:0]                   arst_req_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic [1:0]                     state_o
);

  localparam int IW   = $clog2(N);
  localparam int SW   = $clog2(M);
  localparam int MAXW = (GATE_WAIT > SWITCH_WAIT) ?
                        ((GATE_WAIT > RST_CYCLES) ? GATE_WAIT : RST_CYCLES) :
                        ((SWITCH_WAIT > RST_CYCLES) ? SWITCH_WAIT : RST_CYCLES);
  localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;

  typedef enum logic [1:0] {IDLE, GATE, SWITCH, RESET} state_e;

  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [IW-1:0]          idx_q;
  logic [SW-1:0]          sel_req_q;
  logic                   en_req_q;
  logic                   rst_req_q;
  logic [N-1:0][SW-1:0]   sel_q;
  logic [N-1:0]           en_q;
  logic [N-1:0]           arst_q;
  logic                   done_q;
  logic                   err_q;
`ifdef CRG_SEQ_ABORT_EN
  logic                   en_prev_q;
`endif
  logic                   idx_ok;

  // Handshake: a request is taken on any edge where req_valid_i and
  // req_ready_o are both high; all req_* fields are sampled only on that edge.
  assign req_ready_o = (state_q == IDLE);
  assign idx_ok      = (32'(req_idx_i) < N);

  assign sel_o      = sel_q;
  assign en_o       = en_q;
  assign arst_req_o = arst_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign state_o    = state_q;

  always_ff @(posedge ref_clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      sel_req_q <= '0;
      en_req_q  <= 1'b0;
      rst_req_q <= 1'b0;
      sel_q     <= '0;
      en_q      <= '1;
      arst_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef CRG_SEQ_ABORT_EN
      en_prev_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            if (!idx_ok) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else if (req_sel_i == sel_q[req_idx_i] && !req_rst_i) begin
              // Source unchanged: no glitch risk, so apply the enable directly.
              en_q[req_idx_i] <= req_en_i;
              done_q          <= 1'b1;
            end else begin
              idx_q           <= req_idx_i;
              sel_req_q       <= req_sel_i;
              en_req_q        <= req_en_i;
              rst_req_q       <= req_rst_i;
`ifdef CRG_SEQ_ABORT_EN
              en_prev_q       <= en_q[req_idx_i];
`endif
              en_q[req_idx_i] <= 1'b0;
              cnt_q           <= CW'(GATE_WAIT - 1);
              state_q         <= GATE;
            end
          end
        end
        GATE: begin
`ifdef CRG_SEQ_ABORT_EN
          if (abort_i) begin
            en_q[idx_q] <= en_prev_q;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
            state_q     <= IDLE;
          end else
`endif
          if (cnt_q == '0) begin
            sel_q[idx_q] <= sel_req_q;
            cnt_q        <= CW'(SWITCH_WAIT - 1);
            state_q      <= SWITCH;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        SWITCH: begin
          if (cnt_q == '0) begin
            if (rst_req_q) begin
              arst_q[idx_q] <= 1'b1;
              cnt_q         <= CW'(RST_CYCLES - 1);
              state_q       <= RESET;
            end else begin
              en_q[idx_q] <= en_req_q;
              done_q      <= 1'b1;
              state_q     <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESET: begin
`ifdef CRG_SEQ_ABORT_EN
          if (abort_i || cnt_q == '0) begin
`else
          if (cnt_q == '0) begin
`endif
            arst_q[idx_q] <= 1'b0;
            en_q[idx_q]   <= en_req_q;
            done_q        <= 1'b1;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crg_cfg_sequencer.sv
// Directed self-checking bench for crg_cfg_sequencer with default parameters (M=4, N=8, G=8, S=32, R=16).
module tb_crg_cfg_sequencer;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_idx;
  logic [1:0]      req_sel;
  logic            req_en;
  logic            req_rst;
  logic [7:0][1:0] sel_o;
  logic [7:0]      en_o;
  logic [7:0]      arst_o;
  logic            done_o;
  logic            err_o;
  logic [1:0]      state_o;
`ifdef CRG_SEQ_ABORT_EN
  logic            abort;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0][1:0] exp_sel;
  int cnt_a, cnt_b, first_hi, lat;

  crg_cfg_sequencer dut (
    .ref_clk_i   (clk),
    .arst_ni     (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_idx_i   (req_idx),
    .req_sel_i   (req_sel),
    .req_en_i    (req_en),
    .req_rst_i   (req_rst),
`ifdef CRG_SEQ_ABORT_EN
    .abort_i     (abort),
`endif
    .sel_o       (sel_o),
    .en_o        (en_o),
    .arst_req_o  (arst_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one edge (T0); returns just after T0.
  task automatic do_req(input logic [2:0] idx, input logic [1:0] sel, input logic en, input logic rst);
    req_idx   = idx;
    req_sel   = sel;
    req_en    = en;
    req_rst   = rst;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_idx = '0; req_sel = '0; req_en = 1'b0; req_rst = 1'b0;
`ifdef CRG_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    check("rst_sel", sel_o, 0);
    check("rst_en", en_o, 8'hFF);
    check("rst_arst", arst_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_ready", req_ready, 1);
    rst_n = 1'b1;
    tick();

    // Normal switch without reset: idx 3 -> source 2
    exp_sel = '0;
    do_req(3'd3, 2'd2, 1'b1, 1'b0);
    check("t1_en_gated", en_o[3], 0);
    check("t1_ready_t0", req_ready, 0);
    cnt_a = 0; cnt_b = 0;
    for (int k = 1; k <= 39; k++) begin
      tick();
      if (req_ready) cnt_a++;
      if (done_o) cnt_b++;
      if (k == 7) check("t1_sel_before", sel_o[3], 0);
      if (k == 8) begin
        check("t1_sel_switch", sel_o[3], 2);
        check("t1_en_still0", en_o[3], 0);
      end
    end
    check("t1_ready_low_cycles", cnt_a, 0);
    check("t1_no_early_done", cnt_b, 0);
    tick();
    exp_sel[3] = 2'd2;
    check("t1_en_ungate", en_o[3], 1);
    check("t1_done", done_o, 1);
    check("t1_err", err_o, 0);
    check("t1_ready_back", req_ready, 1);
    tick();
    check("t1_done_pulse", done_o, 0);

    // Switch with reset pulse: idx 5 -> source 1
    do_req(3'd5, 2'd1, 1'b1, 1'b1);
    cnt_a = 0; cnt_b = 0; first_hi = -1;
    for (int k = 1; k <= 56; k++) begin
      tick();
      if (arst_o[5]) begin
        cnt_a++;
        if (first_hi < 0) first_hi = k;
      end
      if ((arst_o & 8'hDF) != 8'h00) cnt_b++;
      if (k == 55) check("t2_done_early", done_o, 0);
    end
    exp_sel[5] = 2'd1;
    check("t2_arst_len", cnt_a, 16);
    check("t2_arst_start", first_hi, 40);
    check("t2_arst_others", cnt_b, 0);
    check("t2_done", done_o, 1);
    check("t2_en", en_o, 8'hFF);
    check("t2_arst_end", arst_o, 0);
    check("t2_sel", sel_o, exp_sel);

    // Fast path: idx 0 already on source 0, disable it
    tick();
    do_req(3'd0, 2'd0, 1'b0, 1'b0);
    check("t3_en", en_o, 8'hFE);
    check("t3_done", done_o, 1);
    check("t3_err", err_o, 0);
    check("t3_ready", req_ready, 1);
    check("t3_sel", sel_o, exp_sel);
    tick();
    check("t3_done_pulse", done_o, 0);

    // Asynchronous reset in the middle of a reset-type request
    do_req(3'd6, 2'd3, 1'b1, 1'b1);
    for (int k = 1; k <= 20; k++) tick();
    check("t4_en_gated", en_o[6], 0);
    rst_n = 1'b0;
    #1;
    check("t4_sel", sel_o, 0);
    check("t4_en", en_o, 8'hFF);
    check("t4_arst", arst_o, 0);
    check("t4_ready", req_ready, 1);
    #2;
    rst_n = 1'b1;
    cnt_b = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (done_o) cnt_b++;
    end
    check("t4_no_done", cnt_b, 0);
    do_req(3'd1, 2'd1, 1'b1, 1'b0);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (done_o && lat == 0) lat = k;
    end
    exp_sel = '0;
    exp_sel[1] = 2'd1;
    check("t4_next_latency", lat, 40);
    check("t4_next_sel", sel_o, exp_sel);

    // Back-to-back: second request held valid during the first
    req_idx = 3'd2; req_sel = 2'd3; req_en = 1'b1; req_rst = 1'b0; req_valid = 1'b1;
    tick();
    req_idx = 3'd4; req_sel = 2'd2; req_en = 1'b0;
    cnt_b = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done_o) cnt_b++;
      if (k == 40) check("t5_ready_at_done", req_ready, 1);
    end
    tick();
    check("t5_b_accepted", req_ready, 0);
    check("t5_b_gated", en_o[4], 0);
    req_valid = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (done_o) cnt_b++;
      if (k == 40) check("t5_b_done", done_o, 1);
    end
    exp_sel[2] = 2'd3;
    exp_sel[4] = 2'd2;
    check("t5_done_count", cnt_b, 2);
    check("t5_sel", sel_o, exp_sel);
    check("t5_en", en_o, 8'hEF);

`ifdef CRG_SEQ_ABORT_EN
    // Abort during GATE on idx 2 (enabled, source 3)
    do_req(3'd2, 2'd1, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_en", en_o[2], 1);
    check("t6_sel", sel_o[2], 3);
    check("t6_done", done_o, 1);
    check("t6_err", err_o, 1);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
